depremuat_buf: RTL
==================

# depremuat_buf

Row reorder buffer sitting after the transform butterfly stages: accepts one row of 4/8/16/32 signed 28-bit coefficients in butterfly (even-first) order, four per cycle, and re-emits the row in natural coefficient order, four per cycle. It is the inverse of the even/odd input permutation applied ahead of the butterflies. Ping-pong banks sustain one beat per cycle when consecutive rows have equal size.

## Interface
- No parameters; data width fixed at 28, maximum row length fixed at 32.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat present
- i_ready  out  1  block can accept a beat this cycle
- i_size  in  2  row length: 0=4, 1=8, 2=16, 3=32; sampled on the first beat of a row only
- i_0..i_3  in  28 each, signed  four coefficients at permuted positions 4b..4b+3 (b = beat index in row)
- o_valid  out  1  output beat valid; no output backpressure
- o_last  out  1  final beat of the row
- o_size  out  2  size of the row being emitted
- o_0..o_3  out  28 each, signed  coefficients at natural indices 4b..4b+3

## Operation
- Permuted order for N points: position p<N/2 holds natural index 2p; position p>=N/2 holds natural index 2(p-N/2)+1. Inverse: natural n sits at position n/2 (n even) or N/2+(n-1)/2 (n odd).
- Beats per row: N/4 (1, 2, 4, 8). Input beat accepted when i_valid && i_ready.
- Two banks, each 32x28 plus a stored 2-bit size and a state: EMPTY, FILLING, FULL, DRAINING.
- Write side: bank pointer wsel, beat counter wcnt. Accepted beat with wcnt=0: latch i_size into bank, bank EMPTY->FILLING (or ->FULL directly for N=4). Beat with wcnt=N/4-1: bank ->FULL, wcnt->0, wsel toggles. Values pass through unmodified; no arithmetic, no saturation.
- Read side: pointer rsel, beat counter rcnt. When bank[rsel] is FULL it goes DRAINING; each cycle one beat is registered onto o_*; after beat N/4-1 bank ->EMPTY, rcnt->0, rsel toggles; if the other bank is already FULL its first beat follows in the very next cycle (no bubble).
- i_ready = (bank[wsel] is EMPTY or FILLING). Deasserts only when both banks hold complete rows not yet freed.
- A bank freed (last beat read) on the same edge the write side wants it: i_ready in that cycle is computed from pre-edge state, so the write waits one cycle; no same-edge reuse.
- i_valid low mid-row: write side holds wcnt; row completes whenever remaining beats arrive. i_size ignored while wcnt!=0.
- Reset (async, any time incl. mid-row): both banks EMPTY, wsel=rsel=0, wcnt=rcnt=0, o_valid=0, o_last=0, o_size=0, o_0..o_3=0; partial rows discarded. Bank contents need not be reset.

## Timing
- i_ready combinational from state registers only (not from i_valid).
- Latency: last input beat of a row accepted at edge E -> first output beat valid in the cycle after edge E+1 (bank FULL at E, first output registered at E+1).
- Output beats of one row are on consecutive cycles, o_last high on beat N/4-1 only; o_valid low and o_* hold last value when idle.
- Equal-size back-to-back rows: i_ready stays 1, o_valid continuous 1 after initial latency.
- Large-then-small rows (e.g. 32 then 4,4): i_ready drops while both banks are full and the 8-beat drain is in progress.

## Test plan
- Reset: rst_n low mid-row -> all outputs 0, i_ready=1; after release a fresh N=4 row in emits correctly with no residue of the partial row.
- N=4, i_0..i_3 = 10,20,30,40 -> one output beat o_0..o_3 = 10,30,20,40, o_last=1, o_size=0, valid two edges after the input edge.
- N=8, beats (0,2,4,6),(1,3,5,7) as values -> beats (0,1,2,3),(4,5,6,7), o_last on second; repeat with -1..-8 style negatives to confirm sign passthrough (e.g. 28'h8000000 unchanged).
- N=32, 8 beats of permuted value = natural index -> 8 output beats 0..31 ascending; ten back-to-back rows -> i_ready constantly 1, o_valid continuous.
- Size mix 32,4,4,4 with i_valid held high -> i_ready low for the predicted cycles, no row lost or reordered, each o_size matches.
- i_valid gaps of 1-3 cycles inside an N=16 row, and i_size toggled on non-first beats -> output identical to gap-free case, o_size=2.

Source files
------------

// File: rtl/depremuat_buf.sv
// Ping-pong row reorder buffer: takes 4..32 coefficients in even-first butterfly order,
// four per beat, and replays each row in natural coefficient order, four per beat.
module depremuat_buf (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [1:0]         i_size,
    input  logic signed [27:0] i_0,
    input  logic signed [27:0] i_1,
    input  logic signed [27:0] i_2,
    input  logic signed [27:0] i_3,
    output logic               o_valid,
    output logic               o_last,
    output logic [1:0]         o_size,
    output logic signed [27:0] o_0,
    output logic signed [27:0] o_1,
    output logic signed [27:0] o_2,
    output logic signed [27:0] o_3
);

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    function automatic logic [2:0] last_beat(input logic [1:0] sz);
        case (sz)
            2'd0:    last_beat = 3'd0;
            2'd1:    last_beat = 3'd1;
            2'd2:    last_beat = 3'd3;
            default: last_beat = 3'd7;
        endcase
    endfunction

    logic [1:0]         state_reg [2];
    logic [1:0]         bsize_reg [2];
    logic               wsel_reg;
    logic               rsel_reg;
    logic [2:0]         wcnt_reg;
    logic [2:0]         rcnt_reg;
    logic signed [27:0] mem [2][32];

    logic signed [27:0] din   [4];
    logic signed [27:0] rdata [4];
    logic [4:0]         waddr [4];
    logic [1:0]         wsize;
    logic [4:0]         whalf;
    logic               wr_en;
    logic               wlast;
    logic               rd_act;
    logic               rlast;

    assign din[0] = i_0;
    assign din[1] = i_1;
    assign din[2] = i_2;
    assign din[3] = i_3;

    // Size comes from the live input only on the first beat; later beats use the latched value.
    assign wsize   = (wcnt_reg == 3'd0) ? i_size : bsize_reg[wsel_reg];
    assign whalf   = 5'd2 << wsize;
    assign i_ready = (state_reg[wsel_reg] == ST_EMPTY) || (state_reg[wsel_reg] == ST_FILLING);
    assign wr_en   = i_valid && i_ready;
    assign wlast   = (wcnt_reg == last_beat(wsize));

    assign rd_act  = (state_reg[rsel_reg] == ST_FULL) || (state_reg[rsel_reg] == ST_DRAINING);
    assign rlast   = (rcnt_reg == last_beat(bsize_reg[rsel_reg]));

    // Each lane scatters its permuted position to the natural index, so reads are linear.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [4:0] pos;
            logic [4:0] pos_hi;
            assign pos    = {wcnt_reg, 2'(gi)};
            assign pos_hi = pos - whalf;
            assign waddr[gi] = (pos < whalf) ? {pos[3:0], 1'b0} : {pos_hi[3:0], 1'b1};
            assign rdata[gi] = mem[rsel_reg][{rcnt_reg, 2'(gi)}];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                mem[wsel_reg][waddr[k]] <= din[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg[0] <= ST_EMPTY;
            state_reg[1] <= ST_EMPTY;
            bsize_reg[0] <= 2'd0;
            bsize_reg[1] <= 2'd0;
            wsel_reg     <= 1'b0;
            rsel_reg     <= 1'b0;
            wcnt_reg     <= 3'd0;
            rcnt_reg     <= 3'd0;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_size       <= 2'd0;
            o_0          <= '0;
            o_1          <= '0;
            o_2          <= '0;
            o_3          <= '0;
        end else begin
            // Write and read sides never touch the same bank on one edge: their state sets are disjoint.
            if (wr_en) begin
                if (wcnt_reg == 3'd0) begin
                    bsize_reg[wsel_reg] <= i_size;
                end
                if (wlast) begin
                    state_reg[wsel_reg] <= ST_FULL;
                    wcnt_reg            <= 3'd0;
                    wsel_reg            <= ~wsel_reg;
                end else begin
                    state_reg[wsel_reg] <= ST_FILLING;
                    wcnt_reg            <= wcnt_reg + 3'd1;
                end
            end

            if (rd_act) begin
                o_valid <= 1'b1;
                o_last  <= rlast;
                o_size  <= bsize_reg[rsel_reg];
                o_0     <= rdata[0];
                o_1     <= rdata[1];
                o_2     <= rdata[2];
                o_3     <= rdata[3];
                if (rlast) begin
                    state_reg[rsel_reg] <= ST_EMPTY;
                    rcnt_reg            <= 3'd0;
                    rsel_reg            <= ~rsel_reg;
                end else begin
                    state_reg[rsel_reg] <= ST_DRAINING;
                    rcnt_reg            <= rcnt_reg + 3'd1;
                end
            end else begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

endmodule
